// File: rtl/vm_order_sequencer.sv
// ----------------------------------------------------------------------------
// vm_order_sequencer
//
// Runs one complete purchase on a vending_machine for a host. The host
// queues coin codes in a small FIFO and starts an order. The sequencer then
// feeds the coins to the machine one at a time, issues the buy, accepts the
// product and counts the returned change. At the end it pulses o_done with
// a status code and the change count.
//
// Handshake semantics (applies to every host/machine signal below):
//   - A coin is fed with a one-cycle o_money_valid pulse. The pop that
//     produces it is only taken in a cycle where i_busy was sampled low.
//   - o_buy is a one-cycle pulse. It is only raised after a cycle with
//     i_busy sampled low.
//   - A product transfer completes on any cycle where o_product_ready=1 and
//     i_product_valid=1.
//   - i_order_start is honoured only while o_order_ready=1. i_coin_push is
//     honoured only while o_coin_full=0.
//   - Every output is driven from a register. No machine input reaches an
//     output combinationally.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_coin_code/push       coin enqueue from the host; o_coin_full = FIFO full
//   i_order_product/start  order request; o_order_ready = idle
//   o_money/o_money_valid  coin delivery to the machine
//   o_product_code/o_buy   buy request to the machine
//   o_product_ready        product acceptance to the machine
//   i_busy, i_product_valid, i_change_valid, i_no_change,
//   i_ready_product_code   machine responses
//   o_done, o_status, o_change_count  order completion report
//   o_dbg_state            current FSM state (debug/observability)
// ----------------------------------------------------------------------------
module vm_order_sequencer #(
  parameter int MONEY_W    = 4,
  parameter int PRODUCT_W  = 3,
  parameter int COIN_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [MONEY_W-1:0]   i_coin_code,
  input  logic                 i_coin_push,
  output logic                 o_coin_full,
  input  logic [PRODUCT_W-1:0] i_order_product,
  input  logic                 i_order_start,
  output logic                 o_order_ready,
  output logic [MONEY_W-1:0]   o_money,
  output logic                 o_money_valid,
  output logic [PRODUCT_W-1:0] o_product_code,
  output logic                 o_buy,
  output logic                 o_product_ready,
  input  logic                 i_busy,
  input  logic                 i_product_valid,
  input  logic                 i_change_valid,
  input  logic                 i_no_change,
  input  logic [PRODUCT_W-1:0] i_ready_product_code,
  output logic                 o_done,
  output logic [1:0]           o_status,
  output logic [7:0]           o_change_count,
  output logic [2:0]           o_dbg_state
);

  localparam int PTR_W = (COIN_DEPTH > 1) ? $clog2(COIN_DEPTH) : 1;
  localparam int CNT_W = $clog2(COIN_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NO_CHANGE = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_MISMATCH  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FEED      = 3'd1,
    S_BUY       = 3'd2,
    S_WAIT_PROD = 3'd3,
    S_COLLECT   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Coin FIFO
  // --------------------------------------------------------------------------
  logic [MONEY_W-1:0] fifo_mem [COIN_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   fifo_cnt_nxt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               feed_gap;   // 1 = this FEED cycle is the gap after a pop

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(COIN_DEPTH));
  assign push       = i_coin_push && !fifo_full;
  // Pop only in a FEED pop cycle with a coin available and the machine free.
  assign pop        = (state == S_FEED) && !feed_gap && !fifo_empty && !i_busy;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_coin_code;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      o_coin_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt    <= fifo_cnt_nxt;
      o_coin_full <= (fifo_cnt_nxt == CNT_W'(COIN_DEPTH));
    end
  end

  // --------------------------------------------------------------------------
  // Response tracking (WAIT_PROD and COLLECT)
  // --------------------------------------------------------------------------
  logic [PRODUCT_W-1:0] prod_q;
  logic [7:0]           chg_cnt;
  logic [7:0]           chg_cnt_nxt;
  logic                 no_change_q;
  logic                 no_change_nxt;
  logic                 mismatch_q;
  logic                 mismatch_nxt;
  logic [TMR_W-1:0]     timer;
  logic                 timer_hit;
  logic                 in_resp;

  assign in_resp       = (state == S_WAIT_PROD) || (state == S_COLLECT);
  assign chg_cnt_nxt   = (in_resp && i_change_valid && (chg_cnt != 8'hFF))
                         ? chg_cnt + 8'd1 : chg_cnt;
  assign no_change_nxt = no_change_q || (in_resp && i_no_change);
  assign mismatch_nxt  = mismatch_q ||
                         ((state == S_WAIT_PROD) && i_product_valid &&
                          (i_ready_product_code != prod_q));
  // The timer reads 0 on the first cycle in a state, so hitting TIMEOUT-1
  // marks the TIMEOUT-th cycle spent there.
  assign timer_hit     = (timer == TMR_W'(TIMEOUT - 1));

  function automatic logic [1:0] final_status(input logic timed_out,
                                              input logic mismatch,
                                              input logic no_change);
    if (timed_out)      return ST_TIMEOUT;
    else if (mismatch)  return ST_MISMATCH;
    else if (no_change) return ST_NO_CHANGE;
    else                return ST_OK;
  endfunction

  // --------------------------------------------------------------------------
  // Order FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      feed_gap        <= 1'b0;
      prod_q          <= '0;
      chg_cnt         <= '0;
      no_change_q     <= 1'b0;
      mismatch_q      <= 1'b0;
      timer           <= '0;
      o_order_ready   <= 1'b1;
      o_money         <= '0;
      o_money_valid   <= 1'b0;
      o_product_code  <= '0;
      o_buy           <= 1'b0;
      o_product_ready <= 1'b0;
      o_done          <= 1'b0;
      o_status        <= '0;
      o_change_count  <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      o_money_valid  <= 1'b0;
      o_money        <= '0;
      o_buy          <= 1'b0;
      o_product_code <= '0;
      o_done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_order_start) begin
            prod_q         <= i_order_product;
            chg_cnt        <= '0;
            no_change_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            timer          <= '0;
            feed_gap       <= 1'b0;
            o_status       <= '0;
            o_change_count <= '0;
            o_order_ready  <= 1'b0;
            state          <= S_FEED;
          end
        end

        S_FEED: begin
          if (feed_gap) begin
            feed_gap <= 1'b0;
          end else if (fifo_empty) begin
            // Nothing left to feed: if the machine is free the buy can be
            // issued right away, otherwise BUY waits for it.
            state <= S_BUY;
            if (!i_busy) begin
              o_buy          <= 1'b1;
              o_product_code <= prod_q;
            end
          end else if (pop) begin
            o_money       <= fifo_mem[rd_ptr];
            o_money_valid <= 1'b1;
            feed_gap      <= 1'b1;
          end
        end

        S_BUY: begin
          if (o_buy) begin
            // Buy pulse is on the wires this cycle; move on next.
            state           <= S_WAIT_PROD;
            o_product_ready <= 1'b1;
            timer           <= '0;
          end else if (!i_busy) begin
            o_buy          <= 1'b1;
            o_product_code <= prod_q;
          end
        end

        S_WAIT_PROD: begin
          chg_cnt     <= chg_cnt_nxt;
          no_change_q <= no_change_nxt;
          if (i_product_valid) begin
            mismatch_q      <= mismatch_nxt;
            o_product_ready <= 1'b0;
            timer           <= '0;
            state           <= S_COLLECT;
          end else if (timer_hit) begin
            o_product_ready <= 1'b0;
            o_done          <= 1'b1;
            o_status        <= final_status(1'b1, mismatch_q, no_change_nxt);
            o_change_count  <= chg_cnt_nxt;
            state           <= S_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_COLLECT: begin
          chg_cnt     <= chg_cnt_nxt;
          no_change_q <= no_change_nxt;
          if (!i_busy || timer_hit) begin
            o_done         <= 1'b1;
            o_status       <= final_status(i_busy, mismatch_q, no_change_nxt);
            o_change_count <= chg_cnt_nxt;
            state          <= S_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_DONE: begin
          o_order_ready <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          o_order_ready   <= 1'b1;
          o_product_ready <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_vm_order_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vm_order_sequencer
//
// Drives whole orders through vm_order_sequencer while playing the vending
// machine. Directed orders come from a vector table. Random orders take their
// expected outcome from a small outcome model. Coins are tracked in a
// scoreboard queue and delivery timing is checked against the cycle formulas.
// ----------------------------------------------------------------------------
module tb_vm_order_sequencer;

  localparam int MONEY_W    = 4;
  localparam int PRODUCT_W  = 3;
  localparam int COIN_DEPTH = 8;
  localparam int TIMEOUT    = 20;

  // DUT signals
  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b1;
  logic [MONEY_W-1:0]   i_coin_code = '0;
  logic                 i_coin_push = 1'b0;
  logic                 o_coin_full;
  logic [PRODUCT_W-1:0] i_order_product = '0;
  logic                 i_order_start = 1'b0;
  logic                 o_order_ready;
  logic [MONEY_W-1:0]   o_money;
  logic                 o_money_valid;
  logic [PRODUCT_W-1:0] o_product_code;
  logic                 o_buy;
  logic                 o_product_ready;
  logic                 i_busy = 1'b0;
  logic                 i_product_valid = 1'b0;
  logic                 i_change_valid = 1'b0;
  logic                 i_no_change = 1'b0;
  logic [PRODUCT_W-1:0] i_ready_product_code = '0;
  logic                 o_done;
  logic [1:0]           o_status;
  logic [7:0]           o_change_count;
  logic [2:0]           o_dbg_state;

  vm_order_sequencer #(
    .MONEY_W(MONEY_W), .PRODUCT_W(PRODUCT_W),
    .COIN_DEPTH(COIN_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_coin_code(i_coin_code), .i_coin_push(i_coin_push),
    .o_coin_full(o_coin_full),
    .i_order_product(i_order_product), .i_order_start(i_order_start),
    .o_order_ready(o_order_ready),
    .o_money(o_money), .o_money_valid(o_money_valid),
    .o_product_code(o_product_code), .o_buy(o_buy),
    .o_product_ready(o_product_ready),
    .i_busy(i_busy), .i_product_valid(i_product_valid),
    .i_change_valid(i_change_valid), .i_no_change(i_no_change),
    .i_ready_product_code(i_ready_product_code),
    .o_done(o_done), .o_status(o_status), .o_change_count(o_change_count),
    .o_dbg_state(o_dbg_state)
  );

  // --------------------------------------------------------------------------
  // Clock and watchdog
  // --------------------------------------------------------------------------
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [MONEY_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Order vectors
  // --------------------------------------------------------------------------
  typedef struct {
    int                   n_coins;
    logic [8:0][3:0]      coins;
    logic [PRODUCT_W-1:0] prod;
    logic [PRODUCT_W-1:0] ret;
    bit                   give;    // machine presents a product
    int                   n_chg;   // change pulses in WAIT_PROD
    bit                   nc;      // no_change pulse in WAIT_PROD
    int                   cb;      // busy cycles in COLLECT, each with change
    int                   bs;      // FEED busy window start cycle
    int                   bl;      // FEED busy window length
    bit                   timing;  // check exact coin/buy cycles
    logic [1:0]           exp_status;
    logic [7:0]           exp_count;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [35:0] coins,
                              input int prod, input int ret, input bit give,
                              input int n_chg, input bit nc, input int cb,
                              input int bs, input int bl, input bit timing,
                              input int st, input int cnt);
    vec_t v;
    v.n_coins = n;         v.coins = coins;
    v.prod = PRODUCT_W'(prod); v.ret = PRODUCT_W'(ret);
    v.give = give;         v.n_chg = n_chg;   v.nc = nc;  v.cb = cb;
    v.bs = bs;             v.bl = bl;         v.timing = timing;
    v.exp_status = 2'(st); v.exp_count = 8'(cnt);
    return v;
  endfunction

  // Outcome model: what the order report must say, from the order's story.
  function automatic logic [1:0] model_status(input vec_t v);
    if (!v.give || v.cb >= TIMEOUT) return 2'b10;
    if (v.ret != v.prod)            return 2'b11;
    if (v.nc)                       return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] model_count(input vec_t v);
    int n;
    n = v.n_chg;
    if (v.give) n += (v.cb < TIMEOUT) ? v.cb : TIMEOUT;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // --------------------------------------------------------------------------
  // Drivers (called just after a rising edge, i.e. within a cycle)
  // --------------------------------------------------------------------------
  task automatic push_coin(input logic [MONEY_W-1:0] code);
    i_coin_code = code;
    i_coin_push = 1'b1;
    if (exp_q.size() < COIN_DEPTH) exp_q.push_back(code);
    @(posedge i_clk); #1;
    i_coin_push = 1'b0;
    check("coin_full", 32'(o_coin_full), 32'(exp_q.size() == COIN_DEPTH));
  endtask

  task automatic run_order(input vec_t v);
    int  c, buy_c, k, d, n_fed;
    bit  done, prev_busy, busy, chg, pv, ncv;
    for (int j = 0; j < v.n_coins; j++) push_coin(v.coins[j]);
    n_fed = exp_q.size();
    check("ready_idle", 32'(o_order_ready), 1);
    i_order_product = v.prod;
    i_order_start   = 1'b1;
    @(posedge i_clk); #1;
    i_order_start = 1'b0;
    check("ready_drop", 32'(o_order_ready), 0);
    c = 1; buy_c = -1; k = 0; done = 0; prev_busy = 0;
    while (!done && c < 400) begin
      // sample this cycle's outputs
      if (o_money_valid) begin
        check("money_after_busy", 32'(prev_busy), 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_coin: got code %0d expected none", o_money);
        end else begin
          check("coin_code", 32'(o_money), 32'(exp_q.pop_front()));
        end
        if (v.timing) check("coin_cycle", c, 2 + 2 * k);
        k++;
      end
      if (o_buy) begin
        check("buy_code", 32'(o_product_code), 32'(v.prod));
        check("buy_after_busy", 32'(prev_busy), 0);
        check("coins_fed", k, n_fed);
        if (v.timing) check("buy_cycle", c, 2 + 2 * n_fed);
        buy_c = c;
      end
      if (o_done) begin
        done = 1;
        check("status", 32'(o_status), 32'(v.exp_status));
        check("change_count", 32'(o_change_count), 32'(v.exp_count));
        if (!v.give) check("timeout_cycle", c, buy_c + 1 + TIMEOUT);
      end
      // drive the machine's responses for this cycle
      busy = (c >= v.bs) && (c < v.bs + v.bl);
      chg = 0; pv = 0; ncv = 0;
      if (!done && buy_c >= 0 && c > buy_c) begin
        d = c - buy_c;
        if (d <= v.n_chg) chg = 1;
        if (v.nc && d == 1) ncv = 1;
        if (v.give && d == v.n_chg + 1) begin
          pv = 1;
          check("product_ready", 32'(o_product_ready), 1);
        end
        if (v.give && d >= v.n_chg + 2 && d < v.n_chg + 2 + v.cb) begin
          busy = 1; chg = 1;
        end
      end
      if (done) busy = 0;
      i_busy = busy; i_change_valid = chg; i_product_valid = pv;
      i_no_change = ncv; i_ready_product_code = pv ? v.ret : '0;
      prev_busy = busy;
      if (!done) begin
        @(posedge i_clk); #1;
        c++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_missing: got no o_done expected one within 400 cycles");
    end
    @(posedge i_clk); #1;
    check("ready_back", 32'(o_order_ready), 1);
    check("status_hold", 32'(o_status), 32'(v.exp_status));
    check("count_hold", 32'(o_change_count), 32'(v.exp_count));
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = mk(3, 36'h952, 4, 4, 1, 2, 0, 0, 0, 0, 1, 2'b00, 2);
    tbl[1] = mk(4, 36'hF731, 1, 1, 1, 0, 0, 0, 2, 5, 0, 2'b00, 0);
    tbl[2] = mk(9, 36'h987654321, 2, 2, 1, 1, 1, 0, 0, 0, 1, 2'b01, 1);
    tbl[3] = mk(0, 36'h0, 3, 3, 0, 3, 0, 0, 0, 0, 1, 2'b10, 3);
    tbl[4] = mk(1, 36'h6, 4, 6, 1, 0, 1, 0, 0, 0, 1, 2'b11, 0);
    tbl[5] = mk(2, 36'hAB, 5, 5, 1, 1, 0, 3, 0, 0, 1, 2'b00, 4);
    tbl[6] = mk(0, 36'h0, 7, 7, 1, 0, 0, 25, 0, 0, 1, 2'b10, 20);
    tbl[7] = mk(2, 36'h3C, 0, 1, 1, 0, 0, 25, 0, 0, 1, 2'b10, 20);

    // reset state
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(o_order_ready), 1);
    check("rst_done", 32'(o_done), 0);
    check("rst_money_valid", 32'(o_money_valid), 0);
    check("rst_buy", 32'(o_buy), 0);
    check("rst_prod_ready", 32'(o_product_ready), 0);
    check("rst_full", 32'(o_coin_full), 0);
    check("rst_status", 32'(o_status), 0);
    check("rst_count", 32'(o_change_count), 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // directed table
    for (int i = 0; i < 8; i++) run_order(tbl[i]);

    // reset in the middle of FEED
    for (int j = 0; j < 3; j++) push_coin(4'(j + 10));
    i_order_product = 3'd2;
    i_order_start   = 1'b1;
    @(posedge i_clk); #1;
    i_order_start = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #2 i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_money_valid", 32'(o_money_valid), 0);
    check("midrst_money", 32'(o_money), 0);
    check("midrst_ready", 32'(o_order_ready), 1);
    check("midrst_full", 32'(o_coin_full), 0);
    check("midrst_state", 32'(o_dbg_state), 0);
    @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge i_clk); #1;
      check("postrst_no_done", 32'(o_done), 0);
      check("postrst_ready", 32'(o_order_ready), 1);
    end
    // an empty order now must feed nothing (FIFO was emptied)
    run_order(mk(0, 36'h0, 6, 6, 1, 2, 0, 0, 0, 0, 1, 2'b00, 2));

    // randomized orders against the outcome model
    for (int i = 0; i < 14; i++) begin
      rv.n_coins = $urandom_range(0, 6);
      rv.coins = '0;
      for (int j = 0; j < rv.n_coins; j++) rv.coins[j] = 4'($urandom_range(1, 15));
      rv.prod  = PRODUCT_W'($urandom_range(0, 7));
      rv.ret   = ($urandom_range(0, 3) == 0) ? PRODUCT_W'($urandom_range(0, 7)) : rv.prod;
      rv.give  = ($urandom_range(0, 4) != 0);
      rv.n_chg = $urandom_range(0, 10);
      rv.nc    = 1'($urandom_range(0, 1));
      rv.cb    = $urandom_range(0, 9);
      if (rv.cb == 9) rv.cb = 25;
      rv.bs    = $urandom_range(1, 6);
      rv.bl    = $urandom_range(0, 6);
      rv.timing = (rv.bl == 0);
      rv.exp_status = model_status(rv);
      rv.exp_count  = model_count(rv);
      run_order(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
